// File: rtl/ula_seq.sv
// Sequential ALU: logic/arith ops done 2 edges after start, shifts take 1 extra edge per bit.
// start is only accepted while idle (including the done cycle); busy covers the op in flight.
module ula_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             Error
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLLV = 4'b0011, OP_SRLV = 4'b0100, OP_SRAV = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110, OP_SLT  = 4'b0111, OP_BNE  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001, OP_SRL  = 4'b1010, OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100, OP_SRA  = 4'b1101, OP_SLTU = 4'b1111;

    state_t           state;
    logic [3:0]       op;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] work;   // holds B; shifted in place for shift ops
    logic [4:0]       cnt;

    logic [4:0]       amt;
    logic             is_shift;
    logic [WIDTH-1:0] sum, diff, res;
    logic             zf, ovf, err;

    always_comb begin
        amt      = shamt;
        is_shift = 1'b0;
        case (ALUControl)
            OP_SLL, OP_SRL, OP_SRA:    is_shift = 1'b1;
            OP_SLLV, OP_SRLV, OP_SRAV: begin
                is_shift = 1'b1;
                amt      = A[4:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        sum  = a_q + work;
        diff = a_q - work;
        res  = '0;
        ovf  = 1'b0;
        err  = 1'b0;
        case (op)
            OP_AND:  res = a_q & work;
            OP_OR:   res = a_q | work;
            OP_XOR:  res = a_q ^ work;
            OP_NOR:  res = ~(a_q | work);
            OP_ADD: begin
                res = sum;
                ovf = (a_q[WIDTH-1] == work[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (a_q[WIDTH-1] != work[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_BNE:  res = diff;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(work)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, a_q < work};
            OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV: res = work;
            default: err = 1'b1;
        endcase
        // BNE drives the branch flag as "not equal" so the branch logic stays uniform
        zf = (op == OP_BNE) ? (a_q != work) : (res == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op       <= '0;
            a_q      <= '0;
            work     <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Result   <= '0;
            Zero     <= 1'b0;
            Overflow <= 1'b0;
            Error    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op   <= ALUControl;
                        a_q  <= A;
                        work <= B;
                        cnt  <= amt;
                        busy <= 1'b1;
                        state <= (is_shift && amt != 5'd0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    case (op)
                        OP_SLL, OP_SLLV: work <= {work[WIDTH-2:0], 1'b0};
                        OP_SRL, OP_SRLV: work <= {1'b0, work[WIDTH-1:1]};
                        default:         work <= {work[WIDTH-1], work[WIDTH-1:1]};
                    endcase
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1)
                        state <= DONE;
                end
                DONE: begin
                    Result   <= res;
                    Zero     <= zf;
                    Overflow <= ovf;
                    Error    <= err;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
